ysyx_24100029_arbiter: RTL
==========================

Name: ysyx_24100029_arbiter

Overview:
- Two-master to one-master AXI4 arbiter placed directly upstream of the CPU address crossbar.
- Merges IFU (read-only) and LSU (read/write) AXI masters into the single AXI master port that feeds the crossbar.
- Allows exactly one outstanding transaction at a time and uses round-robin grant between IFU and LSU.

Parameters:
- ADDR_W, 32, address width on all channels.
- DATA_W, 32, data width on R/W channels.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ifu_ar{addr,valid,id,len,size,burst}  in  32/1/4/8/3/2  IFU read address channel.
- ifu_arready  out  1  IFU AR ready.
- ifu_r{data,resp,valid,last,id}  out  32/2/1/1/4  IFU read data channel.
- ifu_rready  in  1  IFU R ready.
- lsu_ar*/lsu_arready/lsu_r*/lsu_rready  same shapes as IFU  LSU read channels.
- lsu_aw{addr,valid,id,len,size,burst}  in  32/1/4/8/3/2  LSU write address channel.
- lsu_awready  out  1  LSU AW ready.
- lsu_w{data,strb,valid,last}  in  32/4/1/1  LSU write data channel.
- lsu_wready  out  1  LSU W ready.
- lsu_b{resp,valid,id}  out  2/1/4  LSU write response.
- lsu_bready  in  1  LSU B ready.
- out_ar*/out_r*/out_aw*/out_w*/out_b*  mirror directions  downstream master port to crossbar, full AXI4 signal set.

Behaviour:
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR; state register plus 1-bit last_grant register.
- Reset (async, reset=0): state=IDLE, last_grant=IFU, so the first contest goes to LSU.
  - All out_*valid, out_rready, out_bready = 0; all out_* payloads = 0.
  - All master-side ready/valid = 0; payloads = 0.
  - Applies immediately, including mid-transaction. No completion is owed to either master.
- IDLE: no signal is forwarded. All readies to masters = 0.
  - Requests: ifu_arvalid; lsu_arvalid or lsu_awvalid.
  - Arbitration uses only these valids, registered: the grant takes effect the cycle after request visibility, giving a 1-cycle arbitration latency.
  - Only IFU requesting -> IFU_RD. Only LSU -> LSU side.
  - Both requesting -> grant goes to the master not equal to last_grant; last_grant updates on entry.
  - LSU side: lsu_arvalid -> LSU_RD; else lsu_awvalid -> LSU_WR. If both are valid, read wins.
- IFU_RD / LSU_RD: combinational pass-through of the granted AR and R channels to out_ar/out_r.
  - Non-granted master sees arready=0, rvalid=0, awready=0, wready=0, bvalid=0.
  - Exit to IDLE on the cycle after out_rvalid & out_rready & out_rlast.
- Beat counter (9 bit) in read states:
  - Cleared on AR handshake, incremented per R handshake.
  - If rlast arrives with count != arlen (latched at AR handshake), the transaction still terminates. Sticky status bit err_len is set; it is internal, visible to the bench via hierarchy, and cleared by reset.
- LSU_WR: AW, W and B pass through; AW and W are forwarded independently, with no ordering imposed.
  - out_araddr = lsu_awaddr while out_arvalid=0. The crossbar routes writes by araddr.
  - Exit to IDLE on the cycle after out_bvalid & out_bready.
- Read states drive out_aw*/out_w* valids 0 and out_bready 0. LSU_WR drives out_arvalid and out_rready 0.
- Only one transaction is in flight. A new request is not accepted until the FSM is back in IDLE, so there is a minimum 1 idle cycle between transactions.
- rresp/bresp/rid/bid pass through unmodified, including SLVERR/DECERR.
- A valid that drops before the AR/AW handshake in a granted state is not recovered; the FSM waits for the handshake. AXI forbids this, so masters must hold valid.

Test Plan:
- Single IFU read, araddr=0x3000_0000, arlen=0: grant the cycle after arvalid; out_araddr=0x3000_0000; rdata=0xDEADBEEF returned to IFU only; IDLE the cycle after rlast.
- IFU and LSU arvalid in the same cycle from reset: LSU served first. Next contention after completion: IFU granted, then LSU (alternating).
- LSU write awaddr=0x0200_0000, wdata=0x1234, wstrb=0xF, W before AW: out_araddr=0x0200_0000; B okay returned to LSU; ifu_arready stays 0 throughout.
- Burst read arlen=3 with rready toggling: four beats forwarded in order; err_len=0. Repeat with early rlast at beat 2: FSM exits; err_len=1.
- Assert reset in LSU_RD mid-burst: all valids/readies 0 in the same cycle; state=IDLE; a later IFU request is granted normally.
- DECERR bresp=2'b11 from downstream: delivered unchanged on lsu_bresp with matching bid.

Source files
------------

// File: rtl/ysyx_24100029_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one AXI4 master arbiter, one transaction in flight.
// Round-robin grant registered from IDLE (1-cycle arbitration latency), then combinational pass-through.
module ysyx_24100029_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU read
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  input  logic [3:0]            ifu_arid,
  input  logic [7:0]            ifu_arlen,
  input  logic [2:0]            ifu_arsize,
  input  logic [1:0]            ifu_arburst,
  output logic                  ifu_arready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  output logic                  ifu_rlast,
  output logic [3:0]            ifu_rid,
  input  logic                  ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  input  logic [3:0]            lsu_arid,
  input  logic [7:0]            lsu_arlen,
  input  logic [2:0]            lsu_arsize,
  input  logic [1:0]            lsu_arburst,
  output logic                  lsu_arready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  output logic                  lsu_rlast,
  output logic [3:0]            lsu_rid,
  input  logic                  lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  input  logic [3:0]            lsu_awid,
  input  logic [7:0]            lsu_awlen,
  input  logic [2:0]            lsu_awsize,
  input  logic [1:0]            lsu_awburst,
  output logic                  lsu_awready,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  input  logic                  lsu_wvalid,
  input  logic                  lsu_wlast,
  output logic                  lsu_wready,
  output logic [1:0]            lsu_bresp,
  output logic                  lsu_bvalid,
  output logic [3:0]            lsu_bid,
  input  logic                  lsu_bready,
  // downstream master port
  output logic [ADDR_W-1:0]     out_araddr,
  output logic                  out_arvalid,
  output logic [3:0]            out_arid,
  output logic [7:0]            out_arlen,
  output logic [2:0]            out_arsize,
  output logic [1:0]            out_arburst,
  input  logic                  out_arready,
  input  logic [DATA_W-1:0]     out_rdata,
  input  logic [1:0]            out_rresp,
  input  logic                  out_rvalid,
  input  logic                  out_rlast,
  input  logic [3:0]            out_rid,
  output logic                  out_rready,
  output logic [ADDR_W-1:0]     out_awaddr,
  output logic                  out_awvalid,
  output logic [3:0]            out_awid,
  output logic [7:0]            out_awlen,
  output logic [2:0]            out_awsize,
  output logic [1:0]            out_awburst,
  input  logic                  out_awready,
  output logic [DATA_W-1:0]     out_wdata,
  output logic [DATA_W/8-1:0]   out_wstrb,
  output logic                  out_wvalid,
  output logic                  out_wlast,
  input  logic                  out_wready,
  input  logic [1:0]            out_bresp,
  input  logic                  out_bvalid,
  input  logic [3:0]            out_bid,
  output logic                  out_bready
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t     state;
  logic       last_grant;  // 0 = IFU, 1 = LSU
  logic [8:0] beat_cnt;
  logic [7:0] len_q;
  logic       err_len;

  logic ifu_req, lsu_req;
  assign ifu_req = ifu_arvalid;
  assign lsu_req = lsu_arvalid | lsu_awvalid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      beat_cnt   <= 9'd0;
      len_q      <= 8'd0;
      err_len    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_req && (!lsu_req || last_grant)) begin
            state      <= IFU_RD;
            last_grant <= 1'b0;
          end else if (lsu_req) begin
            state      <= lsu_arvalid ? LSU_RD : LSU_WR;
            last_grant <= 1'b1;
          end
        end
        IFU_RD, LSU_RD: begin
          if (out_arvalid && out_arready) begin
            beat_cnt <= 9'd0;
            len_q    <= out_arlen;
          end else if (out_rvalid && out_rready) begin
            beat_cnt <= beat_cnt + 9'd1;
            // a short or long burst still ends the transaction; only the flag records it
            if (out_rlast) begin
              state <= IDLE;
              if (beat_cnt != {1'b0, len_q}) err_len <= 1'b1;
            end
          end
        end
        LSU_WR: begin
          if (out_bvalid && out_bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = 2'b00;
    ifu_rvalid  = 1'b0;
    ifu_rlast   = 1'b0;
    ifu_rid     = 4'h0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = 2'b00;
    lsu_rvalid  = 1'b0;
    lsu_rlast   = 1'b0;
    lsu_rid     = 4'h0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = 2'b00;
    lsu_bvalid  = 1'b0;
    lsu_bid     = 4'h0;
    out_araddr  = '0;
    out_arvalid = 1'b0;
    out_arid    = 4'h0;
    out_arlen   = 8'h0;
    out_arsize  = 3'h0;
    out_arburst = 2'h0;
    out_rready  = 1'b0;
    out_awaddr  = '0;
    out_awvalid = 1'b0;
    out_awid    = 4'h0;
    out_awlen   = 8'h0;
    out_awsize  = 3'h0;
    out_awburst = 2'h0;
    out_wdata   = '0;
    out_wstrb   = '0;
    out_wvalid  = 1'b0;
    out_wlast   = 1'b0;
    out_bready  = 1'b0;
    case (state)
      IFU_RD: begin
        out_araddr  = ifu_araddr;
        out_arvalid = ifu_arvalid;
        out_arid    = ifu_arid;
        out_arlen   = ifu_arlen;
        out_arsize  = ifu_arsize;
        out_arburst = ifu_arburst;
        ifu_arready = out_arready;
        ifu_rdata   = out_rdata;
        ifu_rresp   = out_rresp;
        ifu_rvalid  = out_rvalid;
        ifu_rlast   = out_rlast;
        ifu_rid     = out_rid;
        out_rready  = ifu_rready;
      end
      LSU_RD: begin
        out_araddr  = lsu_araddr;
        out_arvalid = lsu_arvalid;
        out_arid    = lsu_arid;
        out_arlen   = lsu_arlen;
        out_arsize  = lsu_arsize;
        out_arburst = lsu_arburst;
        lsu_arready = out_arready;
        lsu_rdata   = out_rdata;
        lsu_rresp   = out_rresp;
        lsu_rvalid  = out_rvalid;
        lsu_rlast   = out_rlast;
        lsu_rid     = out_rid;
        out_rready  = lsu_rready;
      end
      LSU_WR: begin
        // the crossbar decodes the target from araddr, even for writes
        out_araddr  = lsu_awaddr;
        out_awaddr  = lsu_awaddr;
        out_awvalid = lsu_awvalid;
        out_awid    = lsu_awid;
        out_awlen   = lsu_awlen;
        out_awsize  = lsu_awsize;
        out_awburst = lsu_awburst;
        lsu_awready = out_awready;
        out_wdata   = lsu_wdata;
        out_wstrb   = lsu_wstrb;
        out_wvalid  = lsu_wvalid;
        out_wlast   = lsu_wlast;
        lsu_wready  = out_wready;
        lsu_bresp   = out_bresp;
        lsu_bvalid  = out_bvalid;
        lsu_bid     = out_bid;
        out_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule
